seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Memory-mapped 7-segment display responder at the far end of the CPU data bus. It captures the 32-bit word the CPU stores to the seg7 address (`seg7_we` / `cpuseg7_data` from the bus decoder) and time-multiplexes it as eight hexadecimal digits onto a common-anode 8-digit display. It holds the last written value, scans one digit per `SCAN_DIV` clocks, and optionally blanks leading zeros.

## Interface

- `SCAN_DIV`, default 100000: clock cycles each digit stays lit; legal range ≥ 1 (use 4 in simulation).
- `clk` input 1: system clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `seg7_we` input 1: write strobe from the bus decoder, one cycle per store.
- `cpuseg7_data` input 32: store data; sampled only when `seg7_we`=1.
- `blank_en` input 1: 1 = blank leading-zero digits.
- `disp_data` output 32: currently latched display value (readback/debug).
- `disp_an` output 8: digit enables, active-low one-hot; bit i = digit i; digit 0 is the least significant nibble.
- `disp_seg` output 8: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

## Operation

- **Data register.** On a `clk` edge with `seg7_we`=1 and `rst`=0, `disp_data` ← `cpuseg7_data`. Otherwise it holds. There is no handshake: every strobe is accepted, and back-to-back writes overwrite.
- **Scan counter.** `cnt` counts 0..`SCAN_DIV`-1. When `cnt` = `SCAN_DIV`-1 it wraps to 0 and `idx` (3 bits) increments modulo 8 (7 → 0). With `SCAN_DIV`=1, `idx` advances every cycle.
- **Nibble select.** `nib` = `disp_data[4*idx+3 : 4*idx]`.
- **Blanking.** Digit `idx` is blank when `blank_en`=1, `idx` ≠ 0, and nibbles `idx`..7 of `disp_data` are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- **Hex decode.** Values below are `disp_seg`, active-low, dp off:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
  - blank: FF
- **Outputs are registered.** `disp_an` ← ~(8'b1 << `idx`) and `disp_seg` ← decode(`nib`, blank) are both computed from the pre-edge `idx` and `disp_data`. The anode stays enabled even for a blanked digit; only the segments go dark.
- **Reset.** While `rst`=1 at an edge: `disp_data`=0, `cnt`=0, `idx`=0, `disp_an`=8'hFF, `disp_seg`=8'hFF. Reset overrides a simultaneous `seg7_we`.

## Timing

- `rst` released at edge R: `disp_an`=FE, `disp_seg`=C0 (blank_en irrelevant) after edge R+1.
- **Write latency.** Write sampled at edge W: `disp_data` shows the new value after W. `disp_seg` reflects it after W+1, for whatever digit `idx` currently selects.
- **Write mid-scan.** `cnt` and `idx` are not disturbed; the current digit switches content immediately (after one cycle), without restarting the scan.
- **Digit dwell.** Each digit stays lit exactly `SCAN_DIV` cycles. A full frame is 8·`SCAN_DIV` cycles. The `disp_an` change lags the `idx` change by one cycle.
- **Reset mid-scan.** The next edge with `rst`=1 forces the reset values regardless of `cnt` or `idx`. The scan restarts at digit 0 with a full dwell.
- `blank_en` toggles take effect on the next output register update. No other state is affected.

## Test plan

- **Reset.** Hold `rst` 3 cycles with `seg7_we`=1 and data 0xDEADBEEF → `disp_data`=0, `disp_an`=FF, `disp_seg`=FF. One cycle after release: `disp_an`=FE, `disp_seg`=C0.
- **Full scan** (`SCAN_DIV`=4). Write 0x12345678 with `blank_en`=0 → digits 0..7 show 80, F8, 82, 92, 99, B0, A4, F9 with `disp_an`=FE, FD, FB, F7, EF, DF, BF, 7F, each held exactly 4 cycles. After digit 7, `disp_an` returns to FE.
- **Blanking.** Write 0x000000A5 with `blank_en`=1 → digit 0 = 92, digit 1 = 88, digits 2..7 `disp_seg`=FF while `disp_an` still cycles. Then write 0x00000000 → digit 0 = C0, all others FF. Then clear `blank_en` → all digits C0.
- **Mid-scan write.** While digit 3 is lit with `cnt`=1, write 0x0000F000 → `disp_seg`=8E one cycle later. The dwell ends on schedule, 2 cycles after that.
- **All hex glyphs.** Write 0xFEDCBA98, then 0x76543210 → all 16 decode values match the table above.
- **Reset mid-frame.** Assert `rst` during digit 5 together with `seg7_we` → reset values are produced, the write is discarded, and after release the scan restarts at FE with a 4-cycle dwell.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped 8-digit common-anode hex display: latches the last CPU store and
// scans one nibble per SCAN_DIV clocks, with optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg7_we,
    input  logic [31:0] cpuseg7_data,
    input  logic        blank_en,
    output logic [31:0] disp_data,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg
);
    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0][3:0]  nibs;
    logic [3:0]       nib;
    logic             blank;
    logic [7:0]       seg_next;

    function automatic logic [7:0] hex2seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    assign nibs = disp_data;
    assign nib  = nibs[idx];

    // Digit 0 always shows, so an all-zero word still reads "0".
    assign blank    = blank_en && (idx != 3'd0) && ((disp_data >> {idx, 2'b00}) == 32'd0);
    assign seg_next = blank ? 8'hFF : hex2seg(nib);

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_data <= 32'd0;
            cnt       <= '0;
            idx       <= 3'd0;
            disp_an   <= 8'hFF;
            disp_seg  <= 8'hFF;
        end else begin
            if (seg7_we)
                disp_data <= cpuseg7_data;
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // Outputs use pre-edge idx/data, so the anode lags idx by one cycle.
            disp_an  <= ~(8'b1 << idx);
            disp_seg <= seg_next;
        end
    end
endmodule
